// File: rtl/port_cycle_pkg.sv
// Shared types and constants for the peripheral port cycle arbiter.
package port_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_e;

    // CPU address windows, decoded on A[6:4]
    localparam logic [2:0] WIN_CSS  = 3'b100;
    localparam logic [2:0] WIN_CSX0 = 3'b101;
    localparam logic [2:0] WIN_CSX1 = 3'b110;

    function automatic logic is_window(input logic [2:0] win);
        return (win == WIN_CSS) || (win == WIN_CSX0) || (win == WIN_CSX1);
    endfunction

    // Phase counters count down to zero, so a phase of n cycles loads n-1
    function automatic logic [2:0] phase_load(input int unsigned cycles);
        return 3'(cycles - 1);
    endfunction

endpackage

// File: rtl/port_cycle_arbiter_strobe_sync.sv
// Two-flop synchronizer for the asynchronous CPU bus strobes.
// Resets to 1 so a negated (high) strobe is seen while in reset.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops before anything uses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/port_cycle_arbiter.sv
// Peripheral port cycle arbiter: arbitrates CPU slave accesses against DMA
// transfers and sequences setup/strobe/hold/recovery on the external port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access; grant a pending request (round-robin on a tie)
//   SETUP   | select (_CSx or _DACK) low, DATA_OE high for writes
//   STROBE  | _IOR or _IOW low; RD_LATCH in the last cycle of a read
//   HOLD    | strobe high, select/DATA_OE held; ACK in the first cycle
//   RECOVER | everything deasserted; may grant directly on expiry
//
// All port outputs are registered from the current state, so they trail
// the state register by one clock. Every phase therefore keeps its length
// and an access still costs SETUP+STROBE+HOLD+RECOVER cycles end to end.
module port_cycle_arbiter
    import port_cycle_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       as_n,
    input  logic       ds_n,
    input  logic       r_w,
    input  logic [4:0] addr,
    input  logic       dma_req,
    input  logic       dma_rw,
    output logic       css_n,
    output logic       csx0_n,
    output logic       csx1_n,
    output logic       dack_n,
    output logic       ior_n,
    output logic       iow_n,
    output logic       data_oe,
    output logic       rd_latch,
    output logic       cpu_ack,
    output logic       dma_ack,
    output logic       busy
);

    localparam logic [2:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [2:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [2:0] HOLD_LD   = phase_load(HOLD_CYC);
    localparam logic [2:0] RECOV_LD  = phase_load(RECOV_CYC);

    logic       as_s;
    logic       ds_s;

    state_e     state;
    logic [2:0] cnt;
    grant_e     gnt;
    grant_e     last_grant;
    logic       acc_rd;
    logic [2:0] acc_win;
    logic       cpu_served;
    logic       abort_q;

    logic       cpu_req;
    logic       can_grant;
    logic       grant_cpu;
    logic       grant_dma;
    logic       sel_on;
    logic       hold_first;

    // A[3:2] select registers inside the SDMAC, not peripheral windows
    logic       unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    strobe_sync u_as_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (as_n),
        .q     (as_s)
    );

    strobe_sync u_ds_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ds_n),
        .q     (ds_s)
    );

    // Request qualification and round-robin arbitration
    always_comb begin
        cpu_req    = 1'b0;
        can_grant  = 1'b0;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        sel_on     = 1'b0;
        hold_first = 1'b0;

        // _CS, R_W and ADDR only matter once both strobes are seen low
        if (!as_s && !ds_s) begin
            cpu_req = !cs_n && is_window(addr[4:2]) && !cpu_served;
        end

        can_grant = (state == IDLE) || ((state == RECOVER) && (cnt == 3'd0));

        if (can_grant) begin
            if (cpu_req && dma_req) begin
                grant_cpu = (last_grant == GNT_DMA);
                grant_dma = (last_grant == GNT_CPU);
            end else begin
                grant_cpu = cpu_req;
                grant_dma = dma_req;
            end
        end

        sel_on     = (state == SETUP) || (state == STROBE) || (state == HOLD);
        hold_first = (state == HOLD) && (cnt == HOLD_LD);
    end

    // Cycle sequencer with registered port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            gnt        <= GNT_DMA;
            last_grant <= GNT_DMA;
            acc_rd     <= 1'b0;
            acc_win    <= 3'b000;
            cpu_served <= 1'b0;
            abort_q    <= 1'b0;
            css_n      <= 1'b1;
            csx0_n     <= 1'b1;
            csx1_n     <= 1'b1;
            dack_n     <= 1'b1;
            ior_n      <= 1'b1;
            iow_n      <= 1'b1;
            data_oe    <= 1'b0;
            rd_latch   <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            css_n    <= !(sel_on && (gnt == GNT_CPU) && (acc_win == WIN_CSS));
            csx0_n   <= !(sel_on && (gnt == GNT_CPU) && (acc_win == WIN_CSX0));
            csx1_n   <= !(sel_on && (gnt == GNT_CPU) && (acc_win == WIN_CSX1));
            dack_n   <= !(sel_on && (gnt == GNT_DMA));
            ior_n    <= !((state == STROBE) && acc_rd);
            iow_n    <= !((state == STROBE) && !acc_rd);
            data_oe  <= sel_on && !acc_rd;
            rd_latch <= (state == STROBE) && (cnt == 3'd0) && acc_rd;
            // An abandoned CPU bus cycle still finishes on the port, silently
            cpu_ack  <= hold_first && (gnt == GNT_CPU) && !abort_q && !as_s;
            dma_ack  <= hold_first && (gnt == GNT_DMA);
            busy     <= (state != IDLE);

            // A bus cycle is served once; _AS rising ends it
            if (as_s) begin
                cpu_served <= 1'b0;
            end else if (grant_cpu) begin
                cpu_served <= 1'b1;
            end

            if (grant_cpu || grant_dma) begin
                abort_q <= 1'b0;
            end else if (as_s) begin
                abort_q <= 1'b1;
            end

            case (state)
                IDLE, RECOVER: begin
                    if ((state == RECOVER) && (cnt != 3'd0)) begin
                        cnt <= cnt - 3'd1;
                    end else if (grant_cpu) begin
                        state      <= SETUP;
                        cnt        <= SETUP_LD;
                        gnt        <= GNT_CPU;
                        last_grant <= GNT_CPU;
                        acc_rd     <= r_w;
                        acc_win    <= addr[4:2];
                    end else if (grant_dma) begin
                        state      <= SETUP;
                        cnt        <= SETUP_LD;
                        gnt        <= GNT_DMA;
                        last_grant <= GNT_DMA;
                        acc_rd     <= dma_rw;
                    end else begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end
                end
                SETUP: begin
                    if (cnt == 3'd0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 3'd0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 3'd0) begin
                        state <= RECOVER;
                        cnt   <= RECOV_LD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_cycle_arbiter.sv
// Directed bench for port_cycle_arbiter with an access scoreboard.
module tb_port_cycle_arbiter;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       cs_n    = 1'b1;
    logic       as_n    = 1'b1;
    logic       ds_n    = 1'b1;
    logic       r_w     = 1'b1;
    logic [4:0] addr    = 5'd0;
    logic       dma_req = 1'b0;
    logic       dma_rw  = 1'b0;
    logic       css_n, csx0_n, csx1_n, dack_n, ior_n, iow_n;
    logic       data_oe, rd_latch, cpu_ack, dma_ack, busy;

    port_cycle_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .as_n     (as_n),
        .ds_n     (ds_n),
        .r_w      (r_w),
        .addr     (addr),
        .dma_req  (dma_req),
        .dma_rw   (dma_rw),
        .css_n    (css_n),
        .csx0_n   (csx0_n),
        .csx1_n   (csx1_n),
        .dack_n   (dack_n),
        .ior_n    (ior_n),
        .iow_n    (iow_n),
        .data_oe  (data_oe),
        .rd_latch (rd_latch),
        .cpu_ack  (cpu_ack),
        .dma_ack  (dma_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // sel: 0=_CSS 1=_CSX0 2=_CSX1 3=_DACK
    typedef struct {
        int sel;
        bit wr;
        bit ack;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int sel, input bit wr, input bit ack);
        exp_t e;
        e.sel = sel;
        e.wr  = wr;
        e.ack = ack;
        sb.push_back(e);
    endtask

    // Access monitor: measures each select-low window and scores it
    bit in_acc = 0;
    int m_sel, m_selcyc, m_ior, m_iow, m_oe, m_latch, m_latch_idx;
    int m_cack, m_dack, m_multi;
    int acc_count = 0;
    int tot_cack  = 0;
    int tot_dack  = 0;

    always @(negedge clk) begin
        int   nsel;
        int   code;
        exp_t e;
        if (!rst_n) begin
            in_acc = 0;
        end else begin
            if (cpu_ack) tot_cack++;
            if (dma_ack) tot_dack++;
            nsel = int'(!css_n) + int'(!csx0_n) + int'(!csx1_n) + int'(!dack_n);
            code = !css_n ? 0 : !csx0_n ? 1 : !csx1_n ? 2 : !dack_n ? 3 : -1;
            if (nsel > 0) begin
                if (!in_acc) begin
                    in_acc      = 1;
                    acc_count++;
                    m_sel       = code;
                    m_selcyc    = 0;
                    m_ior       = 0;
                    m_iow       = 0;
                    m_oe        = 0;
                    m_latch     = 0;
                    m_latch_idx = 0;
                    m_cack      = 0;
                    m_dack      = 0;
                    m_multi     = 0;
                end
                m_selcyc++;
                if (nsel > 1) m_multi++;
                if (!ior_n) m_ior++;
                if (!iow_n) m_iow++;
                if (data_oe) m_oe++;
                if (rd_latch) begin
                    m_latch++;
                    m_latch_idx = m_ior;
                end
                if (cpu_ack) m_cack++;
                if (dma_ack) m_dack++;
            end else if (in_acc) begin
                in_acc = 0;
                check("oe_after_access", int'(data_oe), 0);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sel", m_sel, e.sel);
                    check("sel_len", m_selcyc, 5);
                    check("iow_len", m_iow, e.wr ? 3 : 0);
                    check("ior_len", m_ior, e.wr ? 0 : 3);
                    check("data_oe_len", m_oe, e.wr ? 5 : 0);
                    check("rd_latch_cnt", m_latch, e.wr ? 0 : 1);
                    check("rd_latch_idx", m_latch_idx, e.wr ? 0 : 3);
                    check("cpu_ack_cnt", m_cack, (e.sel != 3 && e.ack) ? 1 : 0);
                    check("dma_ack_cnt", m_dack, (e.sel == 3 && e.ack) ? 1 : 0);
                    check("multi_sel", m_multi, 0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edges_until_sel(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (css_n && csx0_n && csx1_n && dack_n && n < 30);
    endtask

    task automatic wait_cpu_ack(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!cpu_ack && n < 60);
        check(tag, int'(cpu_ack), 1);
    endtask

    task automatic wait_dma_ack(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!dma_ack && n < 60);
        check(tag, int'(dma_ack), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (busy && n < 60);
        check(tag, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int nb;
        int t[3];
        logic [4:0] rd_addr[2];
        int         rd_sel[2];

        // Reset values
        #1 rst_n = 1'b0;
        #11;
        check("rst_css_n",    int'(css_n),    1);
        check("rst_csx0_n",   int'(csx0_n),   1);
        check("rst_csx1_n",   int'(csx1_n),   1);
        check("rst_dack_n",   int'(dack_n),   1);
        check("rst_ior_n",    int'(ior_n),    1);
        check("rst_iow_n",    int'(iow_n),    1);
        check("rst_data_oe",  int'(data_oe),  0);
        check("rst_rd_latch", int'(rd_latch), 0);
        check("rst_cpu_ack",  int'(cpu_ack),  0);
        check("rst_dma_ack",  int'(dma_ack),  0);
        check("rst_busy",     int'(busy),     0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // CPU write to 0x40
        push_exp(0, 1'b1, 1'b1);
        addr = 5'h10;
        r_w  = 1'b0;
        cs_n = 1'b0;
        as_n = 1'b0;
        ds_n = 1'b0;
        edges_until_sel(n);
        check("cpu_latency", n, 4);
        check("css_low", int'(css_n), 0);
        wait_cpu_ack("wr40_ack");
        wait_idle("wr40_idle");
        base = acc_count;
        tick(15);
        check("no_repeat_while_as_low", acc_count, base);
        as_n = 1'b1;
        ds_n = 1'b1;
        cs_n = 1'b1;
        tick(4);

        // CPU reads at 0x50 and 0x60
        rd_addr[0] = 5'h14;
        rd_addr[1] = 5'h18;
        rd_sel[0]  = 1;
        rd_sel[1]  = 2;
        for (int i = 0; i < 2; i++) begin
            push_exp(rd_sel[i], 1'b0, 1'b1);
            addr = rd_addr[i];
            r_w  = 1'b1;
            cs_n = 1'b0;
            as_n = 1'b0;
            ds_n = 1'b0;
            wait_cpu_ack("rd_ack");
            as_n = 1'b1;
            ds_n = 1'b1;
            cs_n = 1'b1;
            wait_idle("rd_idle");
            tick(4);
        end

        // Address 0x00 is outside every window
        addr = 5'h00;
        cs_n = 1'b0;
        as_n = 1'b0;
        ds_n = 1'b0;
        base = acc_count;
        nb   = 0;
        repeat (12) begin
            tick(1);
            if (busy) nb++;
        end
        check("nowin_busy_cycles", nb, 0);
        check("nowin_accesses", acc_count, base);
        as_n = 1'b1;
        ds_n = 1'b1;
        cs_n = 1'b1;
        tick(4);

        // DMA write burst of three
        for (int i = 0; i < 3; i++) push_exp(3, 1'b1, 1'b1);
        dma_rw  = 1'b0;
        dma_req = 1'b1;
        edges_until_sel(n);
        check("dma_latency", n, 2);
        check("dack_low", int'(dack_n), 0);
        for (int i = 0; i < 3; i++) begin
            wait_dma_ack("dma_burst_ack");
            t[i] = cyc;
        end
        dma_req = 1'b0;
        check("dma_spacing_1", t[1] - t[0], 7);
        check("dma_spacing_2", t[2] - t[1], 7);
        wait_idle("dma_idle");
        tick(3);

        // CPU and DMA tie after reset: CPU first, then alternate
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        push_exp(0, 1'b1, 1'b1);
        push_exp(3, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b1);
        push_exp(3, 1'b0, 1'b1);
        addr = 5'h10;
        r_w  = 1'b0;
        cs_n = 1'b0;
        as_n = 1'b0;
        ds_n = 1'b0;
        tick(2);
        dma_rw  = 1'b1;
        dma_req = 1'b1;
        wait_cpu_ack("tie_cpu1");
        as_n = 1'b1;
        ds_n = 1'b1;
        tick(3);
        as_n = 1'b0;
        ds_n = 1'b0;
        wait_dma_ack("tie_dma1");
        wait_cpu_ack("tie_cpu2");
        as_n = 1'b1;
        ds_n = 1'b1;
        wait_dma_ack("tie_dma2");
        dma_req = 1'b0;
        cs_n    = 1'b1;
        wait_idle("tie_idle");
        tick(4);

        // Reset during STROBE of a DMA write
        base    = tot_dack;
        dma_rw  = 1'b0;
        dma_req = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (iow_n && n < 30);
        check("rst_test_iow_low", int'(iow_n), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_iow_n",   int'(iow_n),   1);
        check("async_rst_dack_n",  int'(dack_n),  1);
        check("async_rst_data_oe", int'(data_oe), 0);
        check("async_rst_busy",    int'(busy),    0);
        tick(2);
        check("rst_no_ack", tot_dack, base);
        rst_n = 1'b1;
        push_exp(3, 1'b1, 1'b1);
        edges_until_sel(n);
        check("dma_latency_after_rst", n, 2);
        wait_dma_ack("post_rst_ack");
        dma_req = 1'b0;
        wait_idle("post_rst_idle");
        check("post_rst_dma_acks", tot_dack - base, 1);
        tick(3);

        // _AS negated during SETUP, then a fresh bus cycle
        base = tot_cack;
        push_exp(0, 1'b1, 1'b0);
        addr = 5'h10;
        r_w  = 1'b0;
        cs_n = 1'b0;
        as_n = 1'b0;
        ds_n = 1'b0;
        edges_until_sel(n);
        check("abort_css_low", int'(css_n), 0);
        as_n = 1'b1;
        ds_n = 1'b1;
        tick(3);
        push_exp(0, 1'b1, 1'b1);
        as_n = 1'b0;
        ds_n = 1'b0;
        wait_cpu_ack("abort_reissue_ack");
        as_n = 1'b1;
        ds_n = 1'b1;
        cs_n = 1'b1;
        wait_idle("abort_idle");
        tick(3);
        check("abort_cpu_acks", tot_cack - base, 1);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
